// File: rtl/mlaccel_pkg.sv
// Shared types and constants for the mlaccel QPI slave datapath.
// Holds the tx state enum, default turnaround and command opcodes.
package mlaccel_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_TURN  = 2'd1,
        TX_DRIVE = 2'd2
    } tx_state_e;

    localparam int TURNAROUND_DEFAULT = 2;

    localparam logic [7:0] CMD_OP_20 = 8'h20;
    localparam logic [7:0] CMD_OP_21 = 8'h21;
    localparam logic [7:0] CMD_OP_22 = 8'h22;

endpackage

// File: rtl/mlaccel_byte_fifo.sv
// Byte FIFO feeding the QPI transmitter; DEPTH must be a power of 2.
// Ports: clock, reset, flush, push/din, pop/dout, full, empty, count.
module mlaccel_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    // A full FIFO refuses pushes even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mlaccel_qpi_tx.sv
// QPI read-data transmitter: turnaround, then nibbles high-first per qpi_clk fall.
// Ports: clock/reset, qpi_csb_s/qpi_clk_s, tx_start, dout_* byte stream,
// qpi_io_do/qpi_io_oe pads, qpi_err_do underrun, qpi_rdy_do flow control.
// Build option: define MLACCEL_QPI_TX_RDY_EN to drive qpi_rdy_do.
module mlaccel_qpi_tx
    import mlaccel_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TURNAROUND = TURNAROUND_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       qpi_csb_s,
    input  logic       qpi_clk_s,
    input  logic       tx_start,
    input  logic       dout_valid,
    output logic       dout_ready,
    input  logic [7:0] dout_data,
    output logic [3:0] qpi_io_do,
    output logic [3:0] qpi_io_oe,
    output logic       qpi_err_do,
    output logic       qpi_rdy_do
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e     state, state_nx;
    logic [3:0]    turn_cnt, turn_cnt_nx;
    logic          clk_q, fall, slot;
    logic          phase, phase_nx;
    logic [7:0]    hold_q, hold_nx;
    logic [3:0]    do_nx;
    logic          oe_q, oe_nx, err_nx;
    logic          pop_req;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    assign fall = clk_q && !qpi_clk_s;
    // A nibble slot is any fall in DRIVE, or the fall after the
    // turnaround counter has run out, which also enters DRIVE.
    assign slot = fall && (state == TX_DRIVE ||
                  (state == TX_TURN && turn_cnt == 4'd0));

    mlaccel_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (qpi_csb_s),
        .push  (dout_valid),
        .pop   (pop_req),
        .din   (dout_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign dout_ready = !fifo_full;
    assign qpi_io_oe  = {4{oe_q}};

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= TX_IDLE;
            turn_cnt   <= '0;
            clk_q      <= 1'b0;
            phase      <= 1'b0;
            hold_q     <= '0;
            qpi_io_do  <= '0;
            oe_q       <= 1'b0;
            qpi_err_do <= 1'b0;
        end else begin
            state      <= state_nx;
            turn_cnt   <= turn_cnt_nx;
            clk_q      <= qpi_clk_s;
            phase      <= phase_nx;
            hold_q     <= hold_nx;
            qpi_io_do  <= do_nx;
            oe_q       <= oe_nx;
            qpi_err_do <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        turn_cnt_nx = turn_cnt;
        if (qpi_csb_s) begin
            state_nx    = TX_IDLE;
            turn_cnt_nx = '0;
        end else begin
            unique case (state)
                TX_IDLE: begin
                    if (tx_start) begin
                        if (TURNAROUND == 0) begin
                            state_nx = TX_DRIVE;
                        end else begin
                            state_nx    = TX_TURN;
                            turn_cnt_nx = 4'(TURNAROUND);
                        end
                    end
                end
                TX_TURN: begin
                    if (fall) begin
                        if (turn_cnt == 4'd0) begin
                            state_nx = TX_DRIVE;
                        end else begin
                            turn_cnt_nx = turn_cnt - 4'd1;
                        end
                    end
                end
                TX_DRIVE: state_nx = TX_DRIVE;
                default:  state_nx = TX_IDLE;
            endcase
        end
    end

    always_comb begin
        pop_req  = 1'b0;
        phase_nx = phase;
        hold_nx  = hold_q;
        do_nx    = qpi_io_do;
        oe_nx    = oe_q;
        err_nx   = qpi_err_do;
        if (qpi_csb_s) begin
            phase_nx = 1'b0;
            do_nx    = '0;
            oe_nx    = 1'b0;
            err_nx   = 1'b0;
        end else if (slot) begin
            oe_nx = 1'b1;
            if (!phase) begin
                // Underrun substitutes FFh so both nibbles read back as F.
                pop_req  = 1'b1;
                hold_nx  = fifo_empty ? 8'hFF : fifo_dout;
                do_nx    = hold_nx[7:4];
                err_nx   = qpi_err_do || fifo_empty;
                phase_nx = 1'b1;
            end else begin
                do_nx    = hold_q[3:0];
                phase_nx = 1'b0;
            end
        end
    end

`ifdef MLACCEL_QPI_TX_RDY_EN
    logic rdy_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= state != TX_IDLE && fifo_count != '0;
        end
    end
    assign qpi_rdy_do = rdy_q;
`else
    logic unused_fifo_count;
    assign unused_fifo_count = ^fifo_count;
    assign qpi_rdy_do = 1'b0;
`endif

endmodule

// File: tb/tb_mlaccel_qpi_tx.sv
// Bench for mlaccel_qpi_tx: two instances (turnaround 2 and 0) on shared
// QPI control, checked each cycle against a fall-index transaction model.
module tb_mlaccel_qpi_tx;
    localparam int DEPTH = 4;
    localparam int TA0   = 2;
    localparam int TA1   = 0;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            csb = 1'b0;
    logic            qclk = 1'b0;
    logic            tx_start = 1'b0;
    logic [1:0]      valid = '0;
    logic [1:0][7:0] din = '0;
    logic [1:0]      ready;
    logic [1:0][3:0] io_do;
    logic [1:0][3:0] io_oe;
    logic [1:0]      err;
    logic [1:0]      rdy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    mlaccel_qpi_tx #(.FIFO_DEPTH(DEPTH), .TURNAROUND(TA0)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .qpi_csb_s  (csb),
        .qpi_clk_s  (qclk),
        .tx_start   (tx_start),
        .dout_valid (valid[0]),
        .dout_ready (ready[0]),
        .dout_data  (din[0]),
        .qpi_io_do  (io_do[0]),
        .qpi_io_oe  (io_oe[0]),
        .qpi_err_do (err[0]),
        .qpi_rdy_do (rdy[0])
    );

    mlaccel_qpi_tx #(.FIFO_DEPTH(DEPTH), .TURNAROUND(TA1)) u_dut_ta0 (
        .clock      (clock),
        .reset      (reset),
        .qpi_csb_s  (csb),
        .qpi_clk_s  (qclk),
        .tx_start   (tx_start),
        .dout_valid (valid[1]),
        .dout_ready (ready[1]),
        .dout_data  (din[1]),
        .qpi_io_do  (io_do[1]),
        .qpi_io_oe  (io_oe[1]),
        .qpi_err_do (err[1]),
        .qpi_rdy_do (rdy[1])
    );

    // Model: a transaction counts falls since tx_start; the first TA
    // falls are dummies, then even slots pop a byte, odd slots reuse it.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       m_prev = 1'b0;
    logic       m_act [2];
    int         m_k [2];
    logic [7:0] m_hold [2];
    logic [3:0] m_do [2];
    logic       m_oe [2];
    logic       m_err [2];
    logic       m_rdy [2];

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] qpop(input int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic qpush(input int i, input logic [7:0] b);
        if (i == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    task automatic qclr(input int i);
        if (i == 0) q0.delete();
        else q1.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input logic fall);
        int ta, sz, j;
        logic acc, rdy_n;
        logic [7:0] b;
        ta = (i == 0) ? TA0 : TA1;
        if (reset) begin
            m_act[i] = 1'b0; m_k[i] = 0; qclr(i); m_hold[i] = '0;
            m_err[i] = 1'b0; m_do[i] = '0; m_oe[i] = 1'b0;
            m_rdy[i] = 1'b0;
            return;
        end
        sz    = qsize(i);
        acc   = valid[i] && !csb && sz < DEPTH;
        rdy_n = 1'b0;
`ifdef MLACCEL_QPI_TX_RDY_EN
        rdy_n = m_act[i] && sz > 0;
`endif
        if (csb) begin
            m_act[i] = 1'b0; m_k[i] = 0; qclr(i);
            m_err[i] = 1'b0; m_do[i] = '0; m_oe[i] = 1'b0;
        end else if (!m_act[i]) begin
            if (tx_start) begin
                m_act[i] = 1'b1;
                m_k[i]   = 0;
            end
        end else if (fall) begin
            m_k[i]++;
            if (m_k[i] > ta) begin
                j = m_k[i] - ta - 1;
                m_oe[i] = 1'b1;
                if (j % 2 == 0) begin
                    if (sz > 0) b = qpop(i);
                    else begin
                        b = 8'hFF;
                        m_err[i] = 1'b1;
                    end
                    m_hold[i] = b;
                    m_do[i]   = b[7:4];
                end else begin
                    m_do[i] = m_hold[i][3:0];
                end
            end
        end
        if (acc) qpush(i, din[i]);
        m_rdy[i] = rdy_n;
    endtask

    task automatic tick();
        logic fall;
        @(posedge clock);
        fall = m_prev && !qclk;
        for (int i = 0; i < 2; i++) model_step(i, fall);
        m_prev = reset ? 1'b0 : qclk;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("do%0d", i), 32'(io_do[i]), 32'(m_do[i]));
            chk($sformatf("oe%0d", i), 32'(io_oe[i]), 32'({4{m_oe[i]}}));
            chk($sformatf("err%0d", i), 32'(err[i]), 32'(m_err[i]));
            chk($sformatf("rdy%0d", i), 32'(rdy[i]), 32'(m_rdy[i]));
            chk($sformatf("ready%0d", i), 32'(ready[i]),
                32'(qsize(i) < DEPTH));
        end
    endtask

    task automatic push0(input logic [7:0] b);
        valid[0] = 1'b1;
        din[0]   = b;
        tick();
        valid[0] = 1'b0;
    endtask

    task automatic do_fall();
        qclk = 1'b1;
        tick();
        qclk = 1'b0;
        tick();
    endtask

    task automatic start_tx();
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    logic [3:0] seq [4];

    initial begin
        for (int c = 0; c < 3; c++) tick();
        reset = 1'b0;
        tick();
        chk("rst_ready", 32'(ready[0]), 32'd1);
        chk("rst_oe", 32'(io_oe[0]), 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);

        // Two bytes through a turnaround-2 transaction.
        push0(8'hA5);
        push0(8'h3C);
        start_tx();
        do_fall();
        chk("dummy1_oe", 32'(io_oe[0]), 32'd0);
        do_fall();
        chk("dummy2_oe", 32'(io_oe[0]), 32'd0);
        seq[0] = 4'hA; seq[1] = 4'h5; seq[2] = 4'h3; seq[3] = 4'hC;
        for (int n = 0; n < 4; n++) begin
            do_fall();
            chk($sformatf("nib%0d", n), 32'(io_do[0]), 32'(seq[n]));
            chk("drive_oe", 32'(io_oe[0]), 32'hF);
        end
        chk("no_underrun", 32'(err[0]), 32'd0);
        // The turnaround-0 instance had nothing queued.
        chk("ta0_do", 32'(io_do[1]), 32'hF);
        chk("ta0_err", 32'(err[1]), 32'd1);

        csb = 1'b1;
        tick();
        csb = 1'b0;
        chk("err_clr", 32'(err[1]), 32'd0);
        chk("csb_oe", 32'(io_oe[0]), 32'd0);

        // Full FIFO back-pressure.
        for (int n = 0; n < DEPTH; n++) push0(8'(8'h10 + n));
        chk("full_ready", 32'(ready[0]), 32'd0);
        valid[0] = 1'b1;
        din[0]   = 8'h99;
        tick();
        start_tx();
        do_fall();
        do_fall();
        do_fall();
        chk("pop_ready", 32'(ready[0]), 32'd1);
        tick();
        valid[0] = 1'b0;
        chk("refill_ready", 32'(ready[0]), 32'd0);
        do_fall();
        do_fall();

        // Deselect mid-transaction flushes everything.
        csb = 1'b1;
        tick();
        csb = 1'b0;
        chk("flush_oe", 32'(io_oe[0]), 32'd0);
        chk("flush_ready", 32'(ready[0]), 32'd1);
        push0(8'h12);
        push0(8'h34);
        start_tx();
        do_fall();
        do_fall();
        seq[0] = 4'h1; seq[1] = 4'h2; seq[2] = 4'h3; seq[3] = 4'h4;
        for (int n = 0; n < 4; n++) begin
            do_fall();
            chk($sformatf("new_nib%0d", n), 32'(io_do[0]), 32'(seq[n]));
        end

        // Reset while driving releases the pads at once.
        push0(8'h77);
        do_fall();
        reset = 1'b1;
        tick();
        chk("rst_drive_oe", 32'(io_oe[0]), 32'd0);
        chk("rst_drive_rdy", 32'(rdy[0]), 32'd0);
        reset = 1'b0;
        tick();
        push0(8'h55);
        start_tx();
        tick();
`ifdef MLACCEL_QPI_TX_RDY_EN
        chk("turn_rdy", 32'(rdy[0]), 32'd1);
`else
        chk("turn_rdy", 32'(rdy[0]), 32'd0);
`endif

        // Randomized traffic on both instances.
        for (int c = 0; c < 4000; c++) begin
            reset    = ($urandom_range(0, 599) == 0);
            csb      = ($urandom_range(0, 49) == 0);
            tx_start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) qclk = ~qclk;
            for (int i = 0; i < 2; i++) begin
                valid[i] = !csb && ($urandom_range(0, 1) == 1);
                din[i]   = 8'($urandom);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
